// File: rtl/pswr_trig_pkg.sv
// Shared types and defaults for the PSWR trigger generator.
// Optional Pulse_Count output is enabled with PSWR_TRIG_GEN_PULSE_COUNT_EN.
package pswr_trig_pkg;

  typedef enum logic [1:0] {
    TG_IDLE,
    TG_HIGH,
    TG_LOW
  } tg_state_e;

  localparam int unsigned CNT_W_DEF   = 34;
  localparam int unsigned BURST_W_DEF = 16;
  localparam int unsigned MIN_PERIOD  = 2;

endpackage

// File: rtl/pswr_trig_down_counter.sv
// Loadable down-counter with zero flag; times the HIGH and LOW phases of the pulse train.
// Holds at zero rather than wrapping.
module pswr_trig_down_counter #(
  parameter int unsigned CNT_W = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pswr_trigger_generator.sv
// PSWR trigger pulse-train generator: programmable period, high width and burst count.
// Define PSWR_TRIG_GEN_PULSE_COUNT_EN to add the saturating Pulse_Count output.
module pswr_trigger_generator
  import pswr_trig_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stop,
  input  logic [CNT_W-1:0]   Period,
  input  logic [CNT_W-1:0]   Width,
  input  logic [BURST_W-1:0] Burst,
  output logic               Dout,
  output logic               Busy,
  output logic               Done
`ifdef PSWR_TRIG_GEN_PULSE_COUNT_EN
  ,
  output logic [31:0]        Pulse_Count
`endif
);

  tg_state_e          state_q, state_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   high_len_q, high_len_d;
  logic [CNT_W-1:0]   low_len_q, low_len_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               burst_inf_q, burst_inf_d;

  logic               start_acc;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CNT_W-1:0]   per_s;
  logic [CNT_W-1:0]   wid_s;

  // Sanitised operands guarantee 1 <= width < period, so the low length is never zero.
  always_comb begin
    per_s = (Period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : Period;
    wid_s = (Width == '0) ? CNT_W'(1) : Width;
    if (wid_s >= per_s) begin
      wid_s = per_s - CNT_W'(1);
    end
  end

  pswr_trig_down_counter #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    burst_d     = burst_q;
    burst_inf_d = burst_inf_q;
    start_acc   = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;

    if (Stop) begin
      state_d = TG_IDLE;
      dout_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        TG_IDLE: begin
          if (Start) begin
            start_acc   = 1'b1;
            state_d     = TG_HIGH;
            dout_d      = 1'b1;
            busy_d      = 1'b1;
            high_len_d  = wid_s;
            low_len_d   = per_s - wid_s;
            burst_d     = Burst;
            burst_inf_d = (Burst == '0);
            cnt_load    = 1'b1;
            cnt_val     = wid_s - CNT_W'(1);
          end
        end
        TG_HIGH: begin
          if (cnt_zero) begin
            state_d  = TG_LOW;
            dout_d   = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = low_len_q - CNT_W'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        TG_LOW: begin
          if (cnt_zero) begin
            if (!burst_inf_q && (burst_q == BURST_W'(1))) begin
              state_d = TG_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              burst_d = '0;
            end else begin
              if (!burst_inf_q) begin
                burst_d = burst_q - BURST_W'(1);
              end
              state_d  = TG_HIGH;
              dout_d   = 1'b1;
              cnt_load = 1'b1;
              cnt_val  = high_len_q - CNT_W'(1);
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_d = TG_IDLE;
          dout_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= TG_IDLE;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      high_len_q  <= '0;
      low_len_q   <= '0;
      burst_q     <= '0;
      burst_inf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      burst_q     <= burst_d;
      burst_inf_q <= burst_inf_d;
    end
  end

  assign Dout = dout_q;
  assign Busy = busy_q;
  assign Done = done_q;

`ifdef PSWR_TRIG_GEN_PULSE_COUNT_EN
  logic [31:0] pulse_cnt_q, pulse_cnt_d;
  logic [31:0] pulse_base;

  // Clear on accepted Start, then count the rising edge that Start itself produces.
  always_comb begin
    pulse_base  = start_acc ? 32'd0 : pulse_cnt_q;
    pulse_cnt_d = pulse_base;
    if (dout_d && !dout_q && (pulse_base != 32'hFFFF_FFFF)) begin
      pulse_cnt_d = pulse_base + 32'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pulse_cnt_q <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign Pulse_Count = pulse_cnt_q;
`endif

endmodule

// File: tb/tb_pswr_trigger_generator.sv
// Bench for pswr_trigger_generator: directed scenarios plus random traffic against a
// cycle-arithmetic reference model of the pulse train.
module tb_pswr_trigger_generator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Stop  = 1'b0;
  logic [33:0] Period = '0;
  logic [33:0] Width  = '0;
  logic [15:0] Burst  = '0;
  logic        Dout;
  logic        Busy;
  logic        Done;
`ifdef PSWR_TRIG_GEN_PULSE_COUNT_EN
  logic [31:0] Pulse_Count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a train is described by its start cycle and sanitised parameters.
  longint cyc       = 0;
  bit     active    = 0;
  longint t0        = 0;
  longint mp        = 2;
  longint mw        = 1;
  longint mb        = 0;
  bit     prev_dout = 0;
  longint pc        = 0;

  pswr_trigger_generator dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Stop  (Stop),
    .Period(Period),
    .Width (Width),
    .Burst (Burst),
    .Dout  (Dout),
    .Busy  (Busy),
    .Done  (Done)
`ifdef PSWR_TRIG_GEN_PULSE_COUNT_EN
    ,
    .Pulse_Count(Pulse_Count)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model to the next cycle and compare.
  task automatic step(input bit st, input bit sp, input bit rs,
                      input logic [33:0] p, input logic [33:0] w, input logic [15:0] b);
    bit exp_done;
    bit exp_dout;
    Start  = st;
    Stop   = sp;
    Reset  = rs;
    Period = p;
    Width  = w;
    Burst  = b;
    @(posedge Clock);
    exp_done = 0;
    if (rs) begin
      active = 0;
      pc     = 0;
    end else if (sp) begin
      active = 0;
    end else if (!active && st) begin
      active = 1;
      t0     = cyc;
      mp     = (p < 34'd2) ? 2 : longint'(p);
      mw     = (w == 34'd0) ? 1 : longint'(w);
      if (mw >= mp) mw = mp - 1;
      mb     = longint'(b);
      pc     = 0;
    end else if (active && mb != 0 && (cyc - t0) == mb * mp) begin
      active   = 0;
      exp_done = 1;
    end
    exp_dout = active && (((cyc - t0) % mp) < mw);
    if (!rs && exp_dout && !prev_dout && pc < 64'hFFFF_FFFF) pc++;
    prev_dout = exp_dout;
    cyc++;
    #1;
    chk1("dout", Dout, exp_dout);
    chk1("busy", Busy, active);
    chk1("done", Done, exp_done);
`ifdef PSWR_TRIG_GEN_PULSE_COUNT_EN
    chk32("pulse_count", Pulse_Count, pc[31:0]);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 34'd0, 34'd0, 16'd0);
  endtask

  task automatic go(input logic [33:0] p, input logic [33:0] w, input logic [15:0] b);
    step(1, 0, 0, p, w, b);
  endtask

  initial begin
    // Reset state
    step(0, 0, 1, 34'd0, 34'd0, 16'd0);
    step(0, 0, 1, 34'd0, 34'd0, 16'd0);
    idle(2);

    // Period 10, width 3, two pulses
    go(34'd10, 34'd3, 16'd2);
    idle(25);

    // Period and width clamped to 2/1
    go(34'd1, 34'd0, 16'd3);
    idle(10);

    // Width clamped to period-1
    go(34'd10, 34'd12, 16'd1);
    idle(14);

    // Infinite mode, stopped after 50 cycles
    go(34'd4, 34'd2, 16'd0);
    idle(49);
    step(0, 1, 0, 34'd0, 34'd0, 16'd0);
    idle(5);

    // Start and Stop together in IDLE
    step(1, 1, 0, 34'd10, 34'd3, 16'd3);
    idle(3);

    // Start while busy is ignored
    go(34'd10, 34'd3, 16'd3);
    idle(5);
    step(1, 0, 0, 34'd100, 34'd50, 16'd1);
    idle(30);

    // Start held high: back-to-back trains starting in the Done cycle
    for (int i = 0; i < 14; i++) step(1, 0, 0, 34'd4, 34'd1, 16'd1);
    idle(6);

    // Stop in the cycle a burst would finish
    go(34'd4, 34'd1, 16'd1);
    idle(3);
    step(0, 1, 0, 34'd0, 34'd0, 16'd0);
    idle(3);

    // Reset mid-train
    go(34'd10, 34'd3, 16'd0);
    idle(4);
    step(0, 0, 1, 34'd0, 34'd0, 16'd0);
    idle(4);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3) == 0, $urandom_range(59) == 0, $urandom_range(299) == 0,
           34'($urandom_range(13)), 34'($urandom_range(15)), 16'($urandom_range(4)));
    end
    step(0, 1, 0, 34'd0, 34'd0, 16'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
